// File: rtl/regfile_mp.sv
// ============================================================================
// Module   : regfile_mp
// Purpose  : Multi-port register file with write-to-read bypass and busy
//            scoreboard; x0 reads zero and is never busy.
// Revision : 1.0
// ============================================================================
`default_nettype none

module regfile_mp #(
   parameter  int XLEN = 64,
   parameter  int NREG = 32,
   parameter  int NRD  = 2,
   parameter  int NWR  = 2,
   localparam int AW   = $clog2(NREG)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NRD*AW-1:0]   ra,
   output logic [NRD*XLEN-1:0] rd,
   output logic [NRD-1:0]      rrdy,
   input  logic [NWR-1:0]      wvalid,
   input  logic [NWR*AW-1:0]   wa,
   input  logic [NWR*XLEN-1:0] wd,
   input  logic                alloc_valid,
   input  logic [AW-1:0]       alloc_addr,
   input  logic                flush,
   output logic [AW:0]         busy_cnt
);

   logic [XLEN-1:0] regs_q [NREG];
   logic [XLEN-1:0] regs_d [NREG];
   logic [NREG-1:0] busy_q, busy_d;
   logic [NREG-1:0] wr_hit;
   logic [AW:0]     busy_cnt_q, busy_cnt_d;

   always_comb begin
      regs_d     = regs_q;
      wr_hit     = '0;
      busy_d     = '0;
      busy_cnt_d = '0;
      // Ascending port order lets the highest-index writer win a conflict.
      for (int j = 0; j < NWR; j++) begin
         if (wvalid[j] && (wa[j*AW +: AW] != '0)) begin
            regs_d[wa[j*AW +: AW]] = wd[j*XLEN +: XLEN];
            wr_hit[wa[j*AW +: AW]] = 1'b1;
         end
      end
      for (int r = 1; r < NREG; r++) begin
         if (flush)
            busy_d[r] = 1'b0;
         else if (alloc_valid && (alloc_addr == AW'(r)))
            busy_d[r] = 1'b1;
         else if (wr_hit[r])
            busy_d[r] = 1'b0;
         else
            busy_d[r] = busy_q[r];
      end
      for (int r = 0; r < NREG; r++)
         busy_cnt_d = busy_cnt_d + (AW+1)'(busy_d[r]);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < NREG; r++)
            regs_q[r] <= '0;
         busy_q     <= '0;
         busy_cnt_q <= '0;
      end else begin
         regs_q     <= regs_d;
         busy_q     <= busy_d;
         busy_cnt_q <= busy_cnt_d;
      end
   end

   assign busy_cnt = busy_cnt_q;

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0]   rd_addr;
      logic [XLEN-1:0] rd_data;
      logic            rd_rdy;
      logic            rd_hit;

      assign rd_addr = ra[i*AW +: AW];

      always_comb begin
         rd_data = regs_q[rd_addr];
         rd_hit  = 1'b0;
         for (int j = 0; j < NWR; j++) begin
            if (wvalid[j] && (wa[j*AW +: AW] == rd_addr)) begin
               rd_data = wd[j*XLEN +: XLEN];
               rd_hit  = 1'b1;
            end
         end
         if (rd_addr == '0) begin
            rd_data = '0;
            rd_rdy  = 1'b1;
         end else begin
            // A same-cycle alloc belongs to a newer instruction, so it masks the clear.
            rd_rdy = !busy_q[rd_addr] ||
                     (rd_hit && !(alloc_valid && (alloc_addr == rd_addr)));
         end
      end

      assign rd[i*XLEN +: XLEN] = rd_data;
      assign rrdy[i]            = rd_rdy;
   end

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ============================================================================
// Module   : tb_regfile_mp
// Purpose  : Self-checking bench for regfile_mp against an array-based model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_mp;
   localparam int XLEN = 64;
   localparam int NREG = 32;
   localparam int NRD  = 2;
   localparam int NWR  = 2;
   localparam int AW   = 5;

   logic                clk = 1'b0;
   logic                reset = 1'b1;
   logic [NRD*AW-1:0]   ra;
   logic [NRD*XLEN-1:0] rd;
   logic [NRD-1:0]      rrdy;
   logic [NWR-1:0]      wvalid;
   logic [NWR*AW-1:0]   wa;
   logic [NWR*XLEN-1:0] wd;
   logic                alloc_valid;
   logic [AW-1:0]       alloc_addr;
   logic                flush;
   logic [AW:0]         busy_cnt;

   logic [AW-1:0]   t_ra [NRD];
   logic            t_wv [NWR];
   logic [AW-1:0]   t_wa [NWR];
   logic [XLEN-1:0] t_wd [NWR];

   logic [XLEN-1:0] m_mem  [NREG];
   bit              m_busy [NREG];

   int n_checks = 0;
   int n_fails  = 0;

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < NRD; i++) ra[i*AW +: AW] = t_ra[i];
      for (int j = 0; j < NWR; j++) begin
         wvalid[j]            = t_wv[j];
         wa[j*AW +: AW]       = t_wa[j];
         wd[j*XLEN +: XLEN]   = t_wd[j];
      end
   end

   regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) dut (
      .clk(clk), .reset(reset), .ra(ra), .rd(rd), .rrdy(rrdy),
      .wvalid(wvalid), .wa(wa), .wd(wd), .alloc_valid(alloc_valid),
      .alloc_addr(alloc_addr), .flush(flush), .busy_cnt(busy_cnt));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int r = 0; r < NREG; r++) begin
         m_mem[r]  = '0;
         m_busy[r] = 0;
      end
   endtask

   task automatic idle();
      for (int i = 0; i < NRD; i++) t_ra[i] = '0;
      for (int j = 0; j < NWR; j++) begin
         t_wv[j] = 1'b0; t_wa[j] = '0; t_wd[j] = '0;
      end
      alloc_valid = 1'b0; alloc_addr = '0; flush = 1'b0;
   endtask

   // Value a reader should observe: latest port writing the address, else storage.
   function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a);
      logic [XLEN-1:0] v;
      if (a == 0) return '0;
      v = m_mem[a];
      for (int j = 0; j < NWR; j++)
         if (t_wv[j] && t_wa[j] == a) v = t_wd[j];
      return v;
   endfunction

   function automatic logic exp_rrdy(input logic [AW-1:0] a);
      bit written = 0;
      if (a == 0) return 1'b1;
      for (int j = 0; j < NWR; j++)
         if (t_wv[j] && t_wa[j] == a) written = 1;
      if (written && !(alloc_valid && alloc_addr == a)) return 1'b1;
      return !m_busy[a];
   endfunction

   function automatic int model_cnt();
      int c = 0;
      for (int r = 0; r < NREG; r++) c += int'(m_busy[r]);
      return c;
   endfunction

   task automatic check_comb();
      for (int i = 0; i < NRD; i++) begin
         check("rd",   rd[i*XLEN +: XLEN], exp_rd(t_ra[i]));
         check("rrdy", 64'(rrdy[i]),       64'(exp_rrdy(t_ra[i])));
      end
   endtask

   // Clock edge: advance model by applying events oldest-to-newest priority.
   task automatic tick();
      @(posedge clk);
      for (int j = 0; j < NWR; j++)
         if (t_wv[j] && t_wa[j] != 0) begin
            m_mem[t_wa[j]]  = t_wd[j];
            m_busy[t_wa[j]] = 0;
         end
      if (alloc_valid && alloc_addr != 0) m_busy[alloc_addr] = 1;
      if (flush) for (int r = 0; r < NREG; r++) m_busy[r] = 0;
      #1;
      check("busy_cnt", 64'(busy_cnt), 64'(model_cnt()));
   endtask

   initial begin
      idle();
      model_reset();
      #12 reset = 1'b0;
      @(posedge clk); #1;

      // Reset state over every address on every port
      check("busy_cnt_rst", 64'(busy_cnt), 64'd0);
      for (int a = 0; a < NREG; a++) begin
         for (int i = 0; i < NRD; i++) t_ra[i] = AW'(a);
         #1;
         for (int i = 0; i < NRD; i++) begin
            check("rst_rd",   rd[i*XLEN +: XLEN], 64'd0);
            check("rst_rrdy", 64'(rrdy[i]),       64'd1);
         end
      end

      // Same-cycle bypass then stored value
      idle();
      t_wv[0] = 1'b1; t_wa[0] = 5; t_wd[0] = 64'hDEAD_BEEF; t_ra[0] = 5;
      #1 check("bypass5", rd[XLEN-1:0], 64'hDEAD_BEEF);
      tick();
      t_wv[0] = 1'b0;
      #1 check("stored5", rd[XLEN-1:0], 64'hDEAD_BEEF);

      // Write conflict, highest port wins; x0 discards writes
      t_wv[0] = 1'b1; t_wa[0] = 7; t_wd[0] = 64'h11;
      t_wv[1] = 1'b1; t_wa[1] = 7; t_wd[1] = 64'h22; t_ra[1] = 7;
      #1 check("conflict_byp", rd[2*XLEN-1:XLEN], 64'h22);
      tick();
      t_wa[0] = 0; t_wd[0] = 64'hFF; t_wv[1] = 1'b0; t_ra[0] = 0;
      #1 check("conflict_st", rd[2*XLEN-1:XLEN], 64'h22);
      check("x0_byp", rd[XLEN-1:0], 64'd0);
      tick();
      idle();
      #1 check("x0_st", rd[XLEN-1:0], 64'd0);

      // Alloc then writeback clear
      alloc_valid = 1'b1; alloc_addr = 9;
      tick();
      idle(); t_ra[0] = 9;
      #1 check("alloc9_rrdy", 64'(rrdy[0]), 64'd0);
      check("alloc9_cnt", 64'(busy_cnt), 64'd1);
      t_wv[0] = 1'b1; t_wa[0] = 9; t_wd[0] = 64'h99;
      #1 check("wb9_rrdy", 64'(rrdy[0]), 64'd1);
      tick();
      check("wb9_cnt", 64'(busy_cnt), 64'd0);

      // Alloc beats same-cycle write; flush clears all
      idle(); alloc_valid = 1'b1; alloc_addr = 3;
      tick();
      t_wv[1] = 1'b1; t_wa[1] = 3; t_wd[1] = 64'h33; t_ra[0] = 3;
      #1 check("realloc3_rrdy", 64'(rrdy[0]), 64'd0);
      tick();
      check("realloc3_cnt", 64'(busy_cnt), 64'd1);
      idle(); alloc_valid = 1'b1; alloc_addr = 4;
      tick();
      alloc_addr = 6;
      tick();
      check("pre_flush_cnt", 64'(busy_cnt), 64'd3);
      idle(); flush = 1'b1; alloc_valid = 1'b1; alloc_addr = 10;
      tick();
      check("flush_cnt", 64'(busy_cnt), 64'd0);

      // Randomised traffic, addresses biased to a small window for conflicts
      for (int n = 0; n < 400; n++) begin
         idle();
         for (int j = 0; j < NWR; j++) begin
            t_wv[j] = 1'($urandom_range(0, 1));
            t_wa[j] = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            t_wd[j] = {$urandom, $urandom};
         end
         for (int i = 0; i < NRD; i++)
            t_ra[i] = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
         alloc_valid = 1'($urandom_range(0, 1));
         alloc_addr  = AW'($urandom_range(0, 9));
         flush       = ($urandom_range(0, 29) == 0);
         #1 check_comb();
         tick();
      end

      // Asynchronous reset between edges
      idle(); t_wv[0] = 1'b1; t_wa[0] = 8; t_wd[0] = 64'h1234;
      alloc_valid = 1'b1; alloc_addr = 12;
      tick();
      idle(); t_ra[0] = 8;
      #1 check("x8_before", rd[XLEN-1:0], 64'h1234);
      reset = 1'b1;
      model_reset();
      #1 check("async_rd8", rd[XLEN-1:0], 64'd0);
      check("async_cnt", 64'(busy_cnt), 64'd0);
      #1 reset = 1'b0;
      check_comb();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule

`default_nettype wire
